barrier_sync: RTL and testbench
===============================

Name: barrier_sync

Overview:
- Clocked, parametrised barrier aggregator for the multi-port testbench.
- Collects per-participant "good" (barrier-reached) requests from NUM_PORTS participants (MAC ports, CPU/DMA agents).
- Asserts a global proceed once every enabled participant is waiting.
- Runs a cycle-counted inactivity watchdog that latches which participants stalled; supports a per-port enable mask and a barrier counter.

Parameters:
- NUM_PORTS, 5: number of barrier participants (ports plus host agent).
- TIMEOUT_CYCLES, 1000: consecutive inactive cycles in GATHER before timeout; must satisfy 1 <= TIMEOUT_CYCLES < 2**CNT_WIDTH.
- CNT_WIDTH, 16: width of the inactivity counter.
- BCNT_WIDTH, 16: width of the completed-barrier counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- port_mask  in  NUM_PORTS  1 = participant enabled; disabled ports are ignored.
- port_good  in  NUM_PORTS  level; participant has reached barrier.
- port_activity  in  NUM_PORTS  level; participant is doing traffic this cycle.
- err_clear  in  1  single-cycle pulse; clears timeout state.
- barrier_proceed  out  1  registered; all enabled participants at barrier.
- timeout_err  out  1  registered, sticky until err_clear.
- stalled_ports  out  NUM_PORTS  participants not good at timeout.
- barrier_count  out  BCNT_WIDTH  number of barriers completed; wraps.
- state_o  out  2  current FSM state, for debug.

Behaviour:
Derived signals, combinational, evaluated each cycle:
- req = port_good & port_mask
- any_req = |req
- all_req = (port_mask != 0) && ((port_good | ~port_mask) all ones)
- act = |(port_activity & port_mask)

FSM states (encoding): IDLE=0, GATHER=1, PROCEED=2, TIMEOUT=3.

Reset (reset_n low, asynchronous):
- state = IDLE; inactivity counter = 0.
- All outputs 0: barrier_proceed, timeout_err, stalled_ports, barrier_count.

IDLE:
- Outputs barrier_proceed = 0.
- If any_req: go to GATHER and set counter = 0.
- all_req in IDLE still goes to GATHER first; there is no direct IDLE->PROCEED.

GATHER transitions, in priority order:
1. all_req: go to PROCEED; barrier_count += 1, wrapping at 2**BCNT_WIDTH.
2. !any_req (all requests withdrawn): go to IDLE; no error.
3. act: counter = 0.
4. Otherwise counter += 1. When counter == TIMEOUT_CYCLES-1 and the counter increments this cycle:
   - go to TIMEOUT;
   - timeout_err = 1;
   - stalled_ports = port_mask & ~port_good, sampled that cycle.

PROCEED:
- barrier_proceed = 1 (registered, equal to state==PROCEED).
- Hold while any_req. On !any_req go to IDLE; barrier_proceed falls the next cycle.
- The watchdog is not active in PROCEED.

TIMEOUT:
- barrier_proceed = 0; timeout_err and stalled_ports held.
- err_clear: go to IDLE, timeout_err = 0, stalled_ports = 0, counter = 0.
- err_clear in any other state has no effect.

Latency:
- Simultaneous good from IDLE: proceed is high 2 cycles later.
- Last good arriving while in GATHER: proceed is high 1 cycle later.

Timeout boundary:
- All-inactive GATHER entered at cycle t: timeout_err rises at t+TIMEOUT_CYCLES+1.
- Activity on the same cycle the counter would expire resets the counter; no timeout.

Mask rules:
- port_mask is sampled live. Dropping a stuck port's mask bit in GATHER can satisfy all_req next cycle.
- port_mask == 0: all_req is never true, and any_req is never true, so the FSM stays in IDLE.

Other boundaries:
- Reset asserted mid-barrier aborts immediately; barrier_count returns to 0.
- Glitches on port_good during PROCEED do not matter, provided at least one enabled bit stays high.

Test Plan:
1. NUM_PORTS=5, mask=5'h1F; good bits raised one per cycle starting at cycle 10 -> proceed high at cycle 15; goods dropped at cycle 20 -> proceed low at cycle 21; barrier_count=1.
2. mask=5'h1F; all good at once at cycle 5 -> proceed at cycle 7. Repeat 65536 times with BCNT_WIDTH=16 -> barrier_count wraps to 0.
3. TIMEOUT_CYCLES=10; good=5'h1E, port 0 never good, no activity from cycle 3 -> timeout_err at cycle 14, stalled_ports=5'h01, proceed stays 0. err_clear pulse -> IDLE, timeout_err=0.
4. Same as scenario 3, but port_activity[2] pulses every 8 cycles -> no timeout for 200 cycles. Then good[0] set -> proceed 1 cycle later.
5. good=5'h1E stuck in GATHER; mask changed to 5'h1E -> proceed next cycle. mask=0 with goods high -> state stays IDLE.
6. Mid-PROCEED reset_n low for 1 ns (asynchronous, between edges) -> proceed=0 and barrier_count=0 immediately; FSM in IDLE.

Source files
------------

// File: rtl/barrier_sync.sv
// Barrier aggregator: raises barrier_proceed once every enabled participant is waiting,
// with an inactivity watchdog that latches the participants that stalled a barrier.
module barrier_sync #(
    parameter int NUM_PORTS      = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_WIDTH      = 16,
    parameter int BCNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_PORTS-1:0]  port_mask,
    input  logic [NUM_PORTS-1:0]  port_good,
    input  logic [NUM_PORTS-1:0]  port_activity,
    input  logic                  err_clear,
    output logic                  barrier_proceed,
    output logic                  timeout_err,
    output logic [NUM_PORTS-1:0]  stalled_ports,
    output logic [BCNT_WIDTH-1:0] barrier_count,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATHER  = 2'd1,
        PROCEED = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] idle_cnt;
    logic [NUM_PORTS-1:0] req;
    logic                 any_req;
    logic                 all_req;
    logic                 act;
    logic                 waiting;
    logic                 expire;

    assign req     = port_good & port_mask;
    assign any_req = |req;
    assign all_req = (port_mask != '0) && (&(port_good | ~port_mask));
    assign act     = |(port_activity & port_mask);

    // Watchdog only runs while some, but not all, enabled participants wait in GATHER.
    assign waiting = (state == GATHER) && any_req && !all_req;
    assign expire  = waiting && !act && (idle_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GATHER;
            GATHER: begin
                if (all_req)       state_next = PROCEED;
                else if (!any_req) state_next = IDLE;
                else if (expire)   state_next = TIMEOUT;
            end
            PROCEED: if (!any_req) state_next = IDLE;
            TIMEOUT: if (err_clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        state_o = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt        <= '0;
            barrier_proceed <= 1'b0;
            timeout_err     <= 1'b0;
            stalled_ports   <= '0;
            barrier_count   <= '0;
        end else begin
            barrier_proceed <= (state_next == PROCEED);

            if (waiting) begin
                idle_cnt <= act ? '0 : idle_cnt + CNT_WIDTH'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (state == GATHER && all_req) begin
                barrier_count <= barrier_count + BCNT_WIDTH'(1);
            end

            if (expire) begin
                timeout_err   <= 1'b1;
                stalled_ports <= port_mask & ~port_good;
            end else if (state == TIMEOUT && err_clear) begin
                timeout_err   <= 1'b0;
                stalled_ports <= '0;
            end
        end
    end

endmodule

// File: tb/tb_barrier_sync.sv
// Scoreboard bench for barrier_sync: expectations are queued with a due cycle when
// stimulus is driven and compared against the DUT outputs when that cycle arrives.
module tb_barrier_sync;

    localparam int NP = 5;
    localparam int TO = 10;
    localparam int CW = 16;
    localparam int BW = 4;

    localparam int SIG_PROCEED = 0;
    localparam int SIG_TERR    = 1;
    localparam int SIG_STALL   = 2;
    localparam int SIG_COUNT   = 3;
    localparam int SIG_STATE   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] port_mask = '0;
    logic [NP-1:0] port_good = '0;
    logic [NP-1:0] port_activity = '0;
    logic          err_clear = 1'b0;
    logic          barrier_proceed;
    logic          timeout_err;
    logic [NP-1:0] stalled_ports;
    logic [BW-1:0] barrier_count;
    logic [1:0]    state_o;

    barrier_sync #(
        .NUM_PORTS(NP),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(CW),
        .BCNT_WIDTH(BW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .port_mask(port_mask),
        .port_good(port_good),
        .port_activity(port_activity),
        .err_clear(err_clear),
        .barrier_proceed(barrier_proceed),
        .timeout_err(timeout_err),
        .stalled_ports(stalled_ports),
        .barrier_count(barrier_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        int unsigned val;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    int unsigned exp_count = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int unsigned sample(input int sig);
        case (sig)
            SIG_PROCEED: return 32'(barrier_proceed);
            SIG_TERR:    return 32'(timeout_err);
            SIG_STALL:   return 32'(stalled_ports);
            SIG_COUNT:   return 32'(barrier_count);
            default:     return 32'(state_o);
        endcase
    endfunction

    task automatic expect_at(input string tag, input int sig, input int unsigned val,
                             input int unsigned delay);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        e.due = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drain();
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    // One full barrier from IDLE: gather, proceed, release.
    task automatic barrier_once(input string tag);
        port_good = 5'h1F;
        exp_count = (exp_count + 1) % (1 << BW);
        expect_at({tag, "_proceed"}, SIG_PROCEED, 1, 2);
        expect_at({tag, "_count"}, SIG_COUNT, exp_count, 2);
        ticks(2);
        port_good = '0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        #12;
        expect_at("rst_proceed", SIG_PROCEED, 0, 0);
        expect_at("rst_terr", SIG_TERR, 0, 0);
        expect_at("rst_stall", SIG_STALL, 0, 0);
        expect_at("rst_count", SIG_COUNT, 0, 0);
        expect_at("rst_state", SIG_STATE, 0, 0);
        drain();
        reset_n = 1'b1;
        port_mask = 5'h1F;
        ticks(2);

        // Goods arrive one per cycle; the last one lands while already in GATHER.
        for (int i = 0; i < NP; i++) begin
            port_good[i] = 1'b1;
            if (i < NP - 1) begin
                expect_at($sformatf("seq_state_%0d", i), SIG_STATE, 1, 1);
                expect_at($sformatf("seq_noproc_%0d", i), SIG_PROCEED, 0, 1);
            end
            tick();
        end
        exp_count = 1;
        check("seq_proceed", 32'(barrier_proceed), 1);
        check("seq_count", 32'(barrier_count), exp_count);
        // Glitch in PROCEED with one enabled bit still high must not drop proceed.
        port_good = 5'h01;
        expect_at("glitch_proceed", SIG_PROCEED, 1, 1);
        expect_at("glitch_state", SIG_STATE, 2, 1);
        tick();
        port_good = '0;
        expect_at("drop_proceed", SIG_PROCEED, 0, 1);
        expect_at("drop_state", SIG_STATE, 0, 1);
        tick();

        // Simultaneous goods from IDLE: GATHER first, proceed two cycles later.
        port_good = 5'h1F;
        expect_at("simul_state1", SIG_STATE, 1, 1);
        expect_at("simul_noproc", SIG_PROCEED, 0, 1);
        expect_at("simul_proceed", SIG_PROCEED, 1, 2);
        exp_count = 2;
        expect_at("simul_count", SIG_COUNT, exp_count, 2);
        ticks(2);
        port_good = '0;
        tick();

        // Counter wraps back to zero after 2**BW barriers.
        for (int k = 0; k < (1 << BW) - 2; k++) barrier_once($sformatf("wrap%0d", k));
        check("wrap_zero", 32'(barrier_count), 0);

        // Watchdog: port 0 never good, no activity.
        port_good = 5'h1E;
        expect_at("to_gather", SIG_STATE, 1, 1);
        expect_at("to_not_yet", SIG_TERR, 0, TO);
        expect_at("to_err", SIG_TERR, 1, TO + 1);
        expect_at("to_stalled", SIG_STALL, 32'h01, TO + 1);
        expect_at("to_state", SIG_STATE, 3, TO + 1);
        expect_at("to_noproc", SIG_PROCEED, 0, TO + 1);
        ticks(TO + 1);
        err_clear = 1'b0;
        expect_at("to_sticky", SIG_TERR, 1, 3);
        expect_at("to_sticky_stall", SIG_STALL, 32'h01, 3);
        ticks(3);
        err_clear = 1'b1;
        port_good = '0;
        expect_at("clr_err", SIG_TERR, 0, 1);
        expect_at("clr_stall", SIG_STALL, 0, 1);
        expect_at("clr_state", SIG_STATE, 0, 1);
        tick();
        err_clear = 1'b0;
        tick();

        // Activity on the exact expiring cycle restarts the full window.
        port_good = 5'h1E;
        expect_at("edge_saved", SIG_TERR, 0, TO + 1);
        expect_at("edge_late0", SIG_TERR, 0, 2 * TO);
        expect_at("edge_late1", SIG_TERR, 1, 2 * TO + 1);
        ticks(TO);
        port_activity = 5'b00100;
        tick();
        port_activity = '0;
        ticks(TO);
        err_clear = 1'b1;
        port_good = '0;
        expect_at("edge_clr", SIG_TERR, 0, 1);
        tick();
        err_clear = 1'b0;
        tick();

        // Periodic activity keeps the watchdog quiet; last good proceeds next cycle.
        port_good = 5'h1E;
        for (int k = 0; k < 200; k++) begin
            port_activity = (k % 8 == 7) ? 5'b00100 : 5'b00000;
            if (k % 25 == 0) expect_at($sformatf("act_noto_%0d", k), SIG_TERR, 0, 1);
            tick();
        end
        port_activity = '0;
        check("act_state", 32'(state_o), 1);
        port_good = 5'h1F;
        exp_count = 1;
        expect_at("act_proceed", SIG_PROCEED, 1, 1);
        expect_at("act_count", SIG_COUNT, exp_count, 1);
        tick();
        port_good = '0;
        tick();

        // Masking the stuck port out satisfies the barrier.
        port_good = 5'h1E;
        ticks(3);
        check("mask_stuck", 32'(state_o), 1);
        port_mask = 5'h1E;
        exp_count = 2;
        expect_at("mask_proceed", SIG_PROCEED, 1, 1);
        expect_at("mask_count", SIG_COUNT, exp_count, 1);
        tick();
        port_good = '0;
        tick();
        port_mask = '0;
        port_good = 5'h1F;
        for (int k = 0; k < 3; k++) expect_at($sformatf("mask0_idle_%0d", k), SIG_STATE, 0, k + 1);
        ticks(3);
        err_clear = 1'b1;
        expect_at("clr_idle_noeffect", SIG_STATE, 0, 1);
        tick();
        err_clear = 1'b0;

        // Asynchronous reset mid-PROCEED, between clock edges.
        port_mask = 5'h1F;
        ticks(2);
        check("pre_rst_proceed", 32'(barrier_proceed), 1);
        #3;
        reset_n = 1'b0;
        #1;
        expect_at("arst_proceed", SIG_PROCEED, 0, 0);
        expect_at("arst_count", SIG_COUNT, 0, 0);
        expect_at("arst_state", SIG_STATE, 0, 0);
        drain();
        reset_n = 1'b1;
        port_good = '0;
        ticks(2);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
